// File: rtl/grant_pkg.sv
// Shared constants and FSM encoding for the grant decoder slice.
package grant_pkg;

  localparam int IDX_W_DEF = 2;
  localparam int N_DEF     = 1 << IDX_W_DEF;
  localparam int COUNT_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO; pointers wrap naturally, an occupancy count drives full/empty.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == {CNT_W{1'b0}});
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grant_decoder_4bit.sv
// Buffers encoded request indices and presents each as a held one-hot grant until acknowledged.
// Optional hold-limit expiry is enabled by defining GRANT_TIMEOUT_EN.
module grant_decoder_4bit
  import grant_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEF,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15,
  localparam int N      = 2 ** IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   idx,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N-1:0]       grant,
  output logic               grant_valid,
  input  logic               grant_ack,
  output logic [COUNT_W-1:0] grant_count,
  output logic               timeout
);

  localparam int FCNT_W = $clog2(DEPTH + 1);

  state_t             state;
  state_t             next_state;
  logic               fifo_full;
  logic               fifo_empty;
  logic [IDX_W-1:0]   head;
  logic               pop;
  logic               drop;
  logic               expire;
  logic [FCNT_W-1:0]  unused_fifo_count;

  function automatic logic [N-1:0] decode(input logic [IDX_W-1:0] i);
    decode = {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  assign in_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (idx),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  // Next-state and pop decision; a drop (ack or expiry) chains straight into the next index.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = GRANT;
        end else begin
          next_state = IDLE;
        end
      end
      GRANT: begin
        drop = grant_ack || expire;
        if (drop && !fifo_empty) begin
          pop        = 1'b1;
          next_state = GRANT;
        end else if (drop) begin
          next_state = IDLE;
        end else begin
          next_state = GRANT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, registered grant outputs and acknowledged-grant counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= {N{1'b0}};
      grant_valid <= 1'b0;
      grant_count <= {COUNT_W{1'b0}};
    end else begin
      state       <= next_state;
      grant_valid <= (next_state == GRANT);
      if (pop) begin
        grant <= decode(head);
      end else if (next_state == IDLE) begin
        grant <= {N{1'b0}};
      end else begin
        grant <= grant;
      end
      if ((state == GRANT) && grant_ack) begin
        grant_count <= grant_count + COUNT_W'(1'b1);
      end
    end
  end

`ifdef GRANT_TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT + 1);

  logic [HOLD_W-1:0] hold;

  // An ack on the expiry edge wins, so expiry requires grant_ack low.
  assign expire = (state == GRANT) && !grant_ack && (hold == HOLD_W'(TIMEOUT - 1));

  // Hold counter restarts on every grant load; timeout pulses the cycle after expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= {HOLD_W{1'b0}};
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (pop) begin
        hold <= {HOLD_W{1'b0}};
      end else if ((state == GRANT) && !grant_ack) begin
        hold <= hold + HOLD_W'(1'b1);
      end else begin
        hold <= hold;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT > 0);
  assign expire             = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: doc/grant_decoder_4bit.md
Name: grant_decoder_4bit

Overview:
Sequential counterpart to the 4-bit priority encoder/generator. It accepts encoded request indices (Y plus valid) through a ready/valid handshake and buffers them in a small FIFO. Each index is decoded to a one-hot grant, which is held until the consumer acknowledges it. It sits downstream of priority_generator_4bit and drives one-hot select/grant lines into the datapath.

Parameters:
IDX_W, 2, width of the encoded index; grant width N = 2**IDX_W (4).
DEPTH, 2, pending-index FIFO depth; power of two, at least 2.
TIMEOUT, 15, grant hold limit in cycles; used only with GRANT_TIMEOUT_EN.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
idx  input  IDX_W  encoded request index (the priority encoder Y)
in_valid  input  1  idx is valid
in_ready  output  1  FIFO can accept; equals !full
grant  output  N  one-hot decoded grant; all zeros when not granting
grant_valid  output  1  grant is being presented
grant_ack  input  1  consumer accepts the current grant
grant_count  output  8  number of acknowledged grants; wraps 255 -> 0
timeout  output  1  one-cycle pulse when a grant expires (feature only)

Behaviour:
- Reset values, applied at a clock edge with rst=1: grant=0, grant_valid=0, FIFO empty, in_ready=1, grant_count=0, timeout=0, state=IDLE. rst has priority over every other event, so an in-flight grant or buffered index is discarded.
- Push: at an edge where in_valid && in_ready, idx is written to the FIFO tail.
- in_ready = !full. It does not depend on a pop in the same cycle, so nothing is pushed while full even if an ack frees a slot.
- FSM has two states:
  - IDLE: grant_valid=0, grant=0. At an edge with the FIFO non-empty, pop the head, load grant = 1<<head, and go to GRANT.
  - GRANT: grant_valid=1 and grant is held stable.
    - At an edge with grant_ack=1: grant_count += 1.
    - If the FIFO is non-empty at that edge (excluding a same-edge push), pop the next index and stay in GRANT, giving back-to-back grants with no bubble.
    - Otherwise go to IDLE.
- Latency: an index accepted at edge k appears on grant after edge k+1 when the FSM was idle. Minimum input-to-grant latency is 2 cycles (registered; no combinational bypass).
- A push at the same edge as a pop is allowed when not full.
- Simultaneous push to an empty FIFO and IDLE pop is impossible, since the pop sees the pre-edge empty state.
- grant_ack while grant_valid=0 is ignored.
- Ordering is FIFO: grants are issued strictly in acceptance order, with no reprioritisation.
- grant is always exactly one-hot or all zeros.
- FIFO pointers are log2(DEPTH) bits wide, wrap naturally, and use a separate occupancy count (0..DEPTH) for full/empty.

Optional Feature:
GRANT_TIMEOUT_EN
- Defined: a hold counter clears when a grant is loaded and increments each GRANT cycle without an ack.
  - At an edge where the counter equals TIMEOUT-1 and grant_ack=0, the grant is dropped with the same next-grant/IDLE rule as an ack.
  - timeout pulses high for the following cycle.
  - grant_count is not incremented.
  - An ack on the expiry edge wins, and no timeout is reported.
- Not defined: the timeout port is tied to 0, no counter is built, and a grant is held indefinitely.

Decomposition:
- Shared package grant_pkg holds IDX_W/N defaults, the FSM state encoding (IDLE=0, GRANT=1), and the grant_count width constant.
- One sub-module: sync_fifo, a parameterised width/depth synchronous FIFO with push, pop, full, empty and count, on the same clk/rst.
- The decode (1<<idx) and FSM stay in the top-level module.

Test Plan:
1. Reset, then push idx=2; hold grant_ack=0 → grant=4'b0100 and grant_valid=1 two cycles after acceptance, held stable; grant_count=0.
2. Push 0, 3, 1 back-to-back with DEPTH=2 and ack held low → in_ready drops after two buffered entries. Then ack every cycle → grants 0001, 1000, 0010 with no bubble; grant_count=3.
3. Ack pulsed while grant_valid=0 → no state change; grant_count unchanged.
4. Assert rst mid-GRANT with the FIFO holding 2 entries → next cycle grant=0, grant_valid=0, in_ready=1, grant_count=0; no stale grant afterwards.
5. Build with GRANT_TIMEOUT_EN, TIMEOUT=15, push idx=1, never ack → grant drops after 15 GRANT cycles; timeout pulses for exactly 1 cycle; grant_count=0. Repeat with the ack on cycle 15 → no timeout; grant_count=1.
6. Push 256 indices with immediate acks → grant_count wraps to 0; every grant matches 1<<idx in order.
